// File: rtl/controle_busca_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state encoding,
// the PC step and the target-alignment helper.
package controle_busca_pkg;

   typedef enum logic [2:0] {
      INICIO   = 3'd0,
      BUSCA    = 3'd1,
      ENTREGA  = 3'd2,
      DESCARTE = 3'd3,
      ERRO     = 3'd4
   } estado_t;

   localparam logic [31:0] INCREMENTO_PC = 32'd4;

   function automatic logic alvo_desalinhado(input logic [1:0] bits_baixos);
      return (bits_baixos != 2'b00);
   endfunction

endpackage

// File: rtl/controle_busca_incrementador_pc.sv
// Combinational sequential-PC adder; wraps modulo 2^LARGURA.
module incrementador_pc
   import controle_busca_pkg::*;
#(
   parameter int LARGURA = 32
) (
   input  logic [LARGURA-1:0] pc_i,
   output logic [LARGURA-1:0] pc_mais4_o
);

   assign pc_mais4_o = pc_i + LARGURA'(INCREMENTO_PC);

endmodule

// File: rtl/controle_busca.sv
// Instruction-fetch controller: owns the PC, runs the req/ack fetch with the
// instruction memory and hands one instruction at a time to decode.
module controle_busca
   import controle_busca_pkg::*;
#(
   parameter int                 LARGURA    = 32,
   parameter logic [LARGURA-1:0] PC_INICIAL = {LARGURA{1'b0}},
   parameter int                 MAX_ESPERA = 15
) (
   input  logic               clock,
   input  logic               reset,
   output logic               mem_req,
   output logic [LARGURA-1:0] mem_addr,
   input  logic               mem_ack,
   input  logic [LARGURA-1:0] mem_dado,
   output logic [LARGURA-1:0] instr,
   output logic               instr_valida,
   input  logic               stall,
   input  logic               desvio,
   input  logic [LARGURA-1:0] alvo,
   output logic [LARGURA-1:0] pc,
   output logic               erro
);

   localparam int             LC     = $clog2(MAX_ESPERA + 1);
   localparam logic [LC-1:0]  LIMITE = LC'(MAX_ESPERA);
   localparam logic [LC-1:0]  UM     = LC'(1);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] pc_q, pc_d;
   logic [LARGURA-1:0] alvo_pend_q, alvo_pend_d;
   logic [LARGURA-1:0] instr_q, instr_d;
   logic [LC-1:0]      contador_q, contador_d;
   logic               mem_req_q, mem_req_d;
   logic               instr_valida_q, instr_valida_d;
   logic               erro_q, erro_d;

   logic [LARGURA-1:0] pc_mais4_s;
   logic [LC-1:0]      contador_mais1_s;
   logic               desalinhado_s;
   logic               timeout_s;

   incrementador_pc #(.LARGURA(LARGURA)) u_incrementador_pc (
      .pc_i       (pc_q),
      .pc_mais4_o (pc_mais4_s)
   );

   assign contador_mais1_s = contador_q + UM;
   assign timeout_s        = (contador_mais1_s == LIMITE);
   assign desalinhado_s    = desvio && alvo_desalinhado(alvo[1:0]);

   // State register and all datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q       <= INICIO;
         pc_q           <= PC_INICIAL;
         alvo_pend_q    <= {LARGURA{1'b0}};
         instr_q        <= {LARGURA{1'b0}};
         contador_q     <= {LC{1'b0}};
         mem_req_q      <= 1'b0;
         instr_valida_q <= 1'b0;
         erro_q         <= 1'b0;
      end else begin
         estado_q       <= estado_d;
         pc_q           <= pc_d;
         alvo_pend_q    <= alvo_pend_d;
         instr_q        <= instr_d;
         contador_q     <= contador_d;
         mem_req_q      <= mem_req_d;
         instr_valida_q <= instr_valida_d;
         erro_q         <= erro_d;
      end
   end

   // Next-state, PC, pending-target and timeout counter
   always_comb begin
      estado_d    = estado_q;
      pc_d        = pc_q;
      alvo_pend_d = alvo_pend_q;
      contador_d  = contador_q;
      case (estado_q)
         INICIO: begin
            if (desalinhado_s) estado_d = ERRO;
            else               estado_d = BUSCA;
         end
         BUSCA, DESCARTE: begin
            if (desalinhado_s) begin
               estado_d = ERRO;
            end else if (mem_ack) begin
               contador_d = {LC{1'b0}};
               if (desvio) begin
                  pc_d     = alvo;
                  estado_d = BUSCA;
               end else if (estado_q == DESCARTE) begin
                  pc_d     = alvo_pend_q;
                  estado_d = BUSCA;
               end else begin
                  estado_d = ENTREGA;
               end
            end else begin
               // The request already on the bus cannot be withdrawn, so a
               // redirect is parked in alvo_pend until the ack drains it.
               contador_d = contador_mais1_s;
               if (timeout_s) begin
                  estado_d = ERRO;
               end else if (desvio) begin
                  alvo_pend_d = alvo;
                  estado_d    = DESCARTE;
               end else begin
                  estado_d = estado_q;
               end
            end
         end
         ENTREGA: begin
            if (desalinhado_s) begin
               estado_d = ERRO;
            end else if (desvio) begin
               pc_d     = alvo;
               estado_d = BUSCA;
            end else if (stall) begin
               estado_d = ENTREGA;
            end else begin
               pc_d     = pc_mais4_s;
               estado_d = BUSCA;
            end
         end
         ERRO:    estado_d = ERRO;
         default: estado_d = ERRO;
      endcase
   end

   // Output register inputs, decoded from the upcoming state
   always_comb begin
      mem_req_d      = (estado_d == BUSCA) || (estado_d == DESCARTE);
      instr_valida_d = (estado_d == ENTREGA);
      erro_d         = (estado_d == ERRO);
      if ((estado_q == BUSCA) && (estado_d == ENTREGA)) begin
         instr_d = mem_dado;
      end else begin
         instr_d = instr_q;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = pc_q;
   assign instr        = instr_q;
   assign instr_valida = instr_valida_q;
   assign pc           = pc_q;
   assign erro         = erro_q;

endmodule

// File: tb/tb_controle_busca.sv
// Scoreboard bench for controle_busca: expected fetch addresses and deliveries
// are queued by the stimulus and consumed by an independent monitor.
module tb_controle_busca;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req, mem_ack, instr_valida, stall, desvio, erro;
   logic [31:0] mem_addr, mem_dado, instr, alvo, pc;

   int n_cmp  = 0;
   int n_erro = 0;
   int atraso = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entrega_t;

   logic [31:0] fila_addr[$];
   entrega_t    fila_instr[$];

   always #5 clock = ~clock;

   controle_busca #(
      .LARGURA    (32),
      .PC_INICIAL (32'h0000_0000),
      .MAX_ESPERA (15)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_dado     (mem_dado),
      .instr        (instr),
      .instr_valida (instr_valida),
      .stall        (stall),
      .desvio       (desvio),
      .alvo         (alvo),
      .pc           (pc),
      .erro         (erro)
   );

   task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_cmp++;
      if (atual !== esperado) begin
         n_erro++;
         $display("FAIL %s: got %h, expected %h", nome, atual, esperado);
      end
   endtask

   task automatic passo();
      @(negedge clock);
   endtask

   task automatic espera_entrega(input logic [31:0] pc_esp);
      int ciclos = 0;
      while (!(instr_valida === 1'b1 && pc === pc_esp) && ciclos < 100) begin
         passo();
         ciclos++;
      end
      n_cmp++;
      if (ciclos >= 100) begin
         n_erro++;
         $display("FAIL espera_entrega: no delivery at pc %h, got pc %h valid %b", pc_esp, pc, instr_valida);
      end
   endtask

   task automatic espera_instr(input logic [31:0] i, input logic [31:0] p);
      entrega_t e;
      e.instr = i;
      e.pc    = p;
      fila_instr.push_back(e);
   endtask

   // Memory model: acks after 'atraso' waiting cycles, data = address + 1
   initial begin
      int cnt = 0;
      mem_ack  = 1'b0;
      mem_dado = 32'h0;
      forever begin
         @(negedge clock);
         mem_dado = mem_addr + 32'd1;
         if (mem_req === 1'b1 && reset === 1'b0) begin
            if (cnt >= atraso) begin
               mem_ack = 1'b1;
               cnt     = 0;
            end else begin
               mem_ack = 1'b0;
               cnt++;
            end
         end else begin
            mem_ack = 1'b0;
            cnt     = 0;
         end
      end
   end

   // Monitor: a new request or a new delivery pops the scoreboard
   initial begin
      bit          req_ant = 1'b0;
      bit          val_ant = 1'b0;
      logic [31:0] a;
      entrega_t    e;
      forever begin
         @(posedge clock);
         #1;
         if (reset === 1'b1) begin
            req_ant = 1'b0;
            val_ant = 1'b0;
         end else begin
            if (mem_req === 1'b1 && (!req_ant || mem_ack === 1'b1)) begin
               if (fila_addr.size() == 0) begin
                  n_cmp++;
                  n_erro++;
                  $display("FAIL req_inesperada: got addr %h, expected no request", mem_addr);
               end else begin
                  a = fila_addr.pop_front();
                  confere("mem_addr", mem_addr, a);
               end
            end
            if (instr_valida === 1'b1 && !val_ant) begin
               if (fila_instr.size() == 0) begin
                  n_cmp++;
                  n_erro++;
                  $display("FAIL entrega_inesperada: got instr %h pc %h, expected none", instr, pc);
               end else begin
                  e = fila_instr.pop_front();
                  confere("instr", instr, e.instr);
                  confere("pc_entrega", pc, e.pc);
               end
            end
            req_ant = mem_req;
            val_ant = instr_valida;
         end
      end
   end

   initial begin
      reset  = 1'b1;
      stall  = 1'b0;
      desvio = 1'b0;
      alvo   = 32'h0;
      atraso = 0;
      fila_addr.push_back(32'h0);
      fila_addr.push_back(32'h4);
      fila_addr.push_back(32'h8);
      espera_instr(32'h1, 32'h0);
      espera_instr(32'h5, 32'h4);
      espera_instr(32'h9, 32'h8);
      repeat (3) passo();
      confere("rst_pc", pc, 32'h0);
      confere("rst_mem_req", mem_req, 32'h0);
      confere("rst_valida", instr_valida, 32'h0);
      confere("rst_erro", erro, 32'h0);
      confere("rst_instr", instr, 32'h0);
      reset = 1'b0;

      // Free-running fetch, one instruction per two cycles
      espera_entrega(32'h0);
      passo();
      confere("pulso_baixo", instr_valida, 32'h0);
      confere("req_4", mem_req, 32'h1);
      confere("addr_4", mem_addr, 32'h4);
      passo();
      confere("pulso_alto", instr_valida, 32'h1);
      confere("pc_4", pc, 32'h4);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         passo();
         confere("stall_instr", instr, 32'h5);
         confere("stall_pc", pc, 32'h4);
         confere("stall_valida", instr_valida, 32'h1);
         confere("stall_req", mem_req, 32'h0);
      end
      stall = 1'b0;
      passo();
      confere("pos_stall_addr", mem_addr, 32'h8);
      confere("pos_stall_valida", instr_valida, 32'h0);
      passo();
      confere("entrega_8", instr, 32'h9);

      // Redirect from ENTREGA, with stall also high to show desvio wins
      fila_addr.push_back(32'h40);
      espera_instr(32'h41, 32'h40);
      desvio = 1'b1;
      alvo   = 32'h40;
      stall  = 1'b1;
      passo();
      desvio = 1'b0;
      confere("desvio_valida", instr_valida, 32'h0);
      confere("desvio_addr", mem_addr, 32'h40);
      espera_entrega(32'h40);

      // Redirect while a request is outstanding: old fetch drained and dropped
      atraso = 3;
      fila_addr.push_back(32'h44);
      fila_addr.push_back(32'h80);
      espera_instr(32'h81, 32'h80);
      stall = 1'b0;
      passo();
      stall  = 1'b1;
      desvio = 1'b1;
      alvo   = 32'h80;
      confere("descarte_addr0", mem_addr, 32'h44);
      for (int i = 0; i < 3; i++) begin
         passo();
         desvio = 1'b0;
         confere("descarte_addr", mem_addr, 32'h44);
         confere("descarte_req", mem_req, 32'h1);
         confere("descarte_valida", instr_valida, 32'h0);
      end
      passo();
      confere("pos_descarte_addr", mem_addr, 32'h80);
      confere("pos_descarte_valida", instr_valida, 32'h0);
      espera_entrega(32'h80);

      // Misaligned target: sticky error, PC kept
      atraso = 0;
      desvio = 1'b1;
      alvo   = 32'h42;
      passo();
      desvio = 1'b0;
      confere("desal_erro", erro, 32'h1);
      confere("desal_pc", pc, 32'h80);
      confere("desal_req", mem_req, 32'h0);
      confere("desal_valida", instr_valida, 32'h0);
      repeat (3) passo();
      confere("desal_erro_fixo", erro, 32'h1);
      confere("desal_req_fixo", mem_req, 32'h0);

      reset = 1'b1;
      repeat (2) passo();
      confere("rst2_pc", pc, 32'h0);
      confere("rst2_erro", erro, 32'h0);

      // Memory never answers: timeout after MAX_ESPERA cycles of waiting
      atraso = 1000;
      fila_addr.push_back(32'h0);
      reset = 1'b0;
      repeat (15) passo();
      confere("espera_req", mem_req, 32'h1);
      confere("espera_erro", erro, 32'h0);
      passo();
      confere("timeout_erro", erro, 32'h1);
      confere("timeout_req", mem_req, 32'h0);
      repeat (4) passo();
      confere("timeout_erro_fixo", erro, 32'h1);
      confere("timeout_req_fixo", mem_req, 32'h0);

      reset = 1'b1;
      repeat (2) passo();
      confere("rst3_pc", pc, 32'h0);
      confere("rst3_erro", erro, 32'h0);

      // PC wrap from the top of the address space
      atraso = 0;
      stall  = 1'b1;
      fila_addr.push_back(32'h0);
      espera_instr(32'h1, 32'h0);
      fila_addr.push_back(32'hFFFF_FFFC);
      espera_instr(32'hFFFF_FFFD, 32'hFFFF_FFFC);
      fila_addr.push_back(32'h0);
      espera_instr(32'h1, 32'h0);
      reset = 1'b0;
      espera_entrega(32'h0);
      desvio = 1'b1;
      alvo   = 32'hFFFF_FFFC;
      passo();
      desvio = 1'b0;
      confere("topo_addr", mem_addr, 32'hFFFF_FFFC);
      espera_entrega(32'hFFFF_FFFC);
      stall = 1'b0;
      passo();
      stall = 1'b1;
      confere("wrap_addr", mem_addr, 32'h0);
      confere("wrap_req", mem_req, 32'h1);
      confere("wrap_erro", erro, 32'h0);
      espera_entrega(32'h0);
      confere("wrap_erro_final", erro, 32'h0);

      repeat (3) passo();
      confere("fila_addr_vazia", 32'(fila_addr.size()), 32'h0);
      confere("fila_instr_vazia", 32'(fila_instr.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_erro);
      $finish;
   end

endmodule
